hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline sequencing controller for the 5-stage RISC-V core, working alongside the forwarding unit. It covers the hazards forwarding cannot resolve:
- load-use stalls,
- taken-branch flushes,
- multi-cycle data-memory waits.

It also inserts a startup bubble after reset and halts the pipeline on a memory timeout. It drives the PC and the pipeline-register write-enable, flush and freeze controls.

## Interface
- STARTUP_CYCLES, 2: bubble cycles forced after reset release; legal range 1..15.
- TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before halting; legal range 1..255.
- CNT_W, 16: width of the performance counters.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- IFID_rs1, IFID_rs2  input  5 each  source registers of the instruction in ID.
- IDEX_rd  input  5  destination register of the instruction in EX.
- IDEX_MemRead  input  1  the instruction in EX is a load.
- Branch_Taken  input  1  a branch or jump resolved taken in EX.
- Dmem_Req  input  1  the MEM stage is accessing data memory this cycle.
- Dmem_Ready  input  1  the data memory completes the access this cycle.
- PC_Write  output  1  PC update enable.
- IFID_Write  output  1  IF/ID register write enable.
- IFID_Flush  output  1  zero the IF/ID register (insert NOP).
- IDEX_Flush  output  1  zero the ID/EX control bits (insert bubble).
- Pipe_Freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- Mem_Timeout  output  1  sticky error flag.
- Load_Stall_Cnt, Flush_Cnt, Wait_Cnt  output  CNT_W each  present only with HAZARD_PERF_CNT_EN.

## Operation
States: STARTUP, RUN, MEM_WAIT, HALT.

Definitions used below:
- mem_busy = Dmem_Req & ~Dmem_Ready.
- load_use = IDEX_MemRead & (IDEX_rd != 0) & (IDEX_rd == IFID_rs1 | IDEX_rd == IFID_rs2).

STARTUP (entered on reset):
- Outputs: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, Pipe_Freeze=0.
- A down-counter loaded with STARTUP_CYCLES moves the FSM to RUN when it reaches 1.

RUN and MEM_WAIT share one output rule set. It is Mealy and evaluated in this priority order:
1. mem_busy: PC_Write=0, IFID_Write=0, Pipe_Freeze=1, both flushes 0.
2. Branch_Taken: PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1.
3. load_use: PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0.
4. Otherwise: PC_Write=1, IFID_Write=1, all other controls 0.

Branch_Taken and load_use together: the branch wins, because the dependent instruction is flushed anyway.

RUN transitions:
- To MEM_WAIT when mem_busy; the wait counter is cleared to 1.

MEM_WAIT transitions and counter:
- The wait counter increments each cycle mem_busy holds.
- Dmem_Ready returns the FSM to RUN. That cycle's outputs follow rules 2-4, so a branch or load-use held during the wait is acted on in exactly that cycle.
- If the wait counter equals TIMEOUT while mem_busy is still 1, the FSM moves to HALT and sets Mem_Timeout.
- A Dmem_Req drop without Dmem_Ready also returns the FSM to RUN.

HALT:
- PC_Write=0, IFID_Write=0, Pipe_Freeze=1, both flushes 0, Mem_Timeout=1.
- Exit only via rst.

Reset (rst asserted at any time, including mid-wait or in HALT):
- FSM goes to STARTUP immediately and the startup counter reloads.
- Mem_Timeout=0; all counters 0.
- Outputs show STARTUP values while rst is high.

## Timing
- Decision latency: 0 cycles. Outputs are combinational from the registered state and the current inputs.
- State, counters and Mem_Timeout update on the clk rising edge.
- Load-use costs exactly 1 bubble cycle. By the next cycle the load has moved to MEM and the forwarding unit covers the dependency.
- Taken branch costs exactly 2 flushed slots (IF/ID and ID/EX), both asserted in the same cycle.
- A memory wait of N cycles freezes the pipeline for exactly N cycles.
- HALT is entered on the edge ending the TIMEOUT-th busy cycle.
- After rst falls, the first RUN cycle is STARTUP_CYCLES edges later.

## Configuration
- HAZARD_PERF_CNT_EN defined: three saturating counters are built (they stick at 2^CNT_W-1):
  - Load_Stall_Cnt: +1 per cycle in which rule 3 is applied.
  - Flush_Cnt: +1 per cycle in which rule 2 is applied.
  - Wait_Cnt: +1 per cycle in which rule 1 is applied or the FSM is in HALT.
- HAZARD_PERF_CNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset and startup: rst=1 for 3 cycles, then release with STARTUP_CYCLES=2 -> flushes=1 and PC_Write=0 for 2 cycles, then PC_Write=1 in RUN.
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1. With IDEX_rd=0 -> no stall.
- Branch plus load-use in the same cycle -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1; no stall cycle follows.
- Memory wait: Dmem_Req=1, Dmem_Ready=0 for 4 cycles then 1, with Branch_Taken held -> Pipe_Freeze=1 for 4 cycles, then both flushes in the ready cycle, then RUN.
- Timeout: TIMEOUT=15, Dmem_Ready stuck at 0 -> HALT after 15 cycles with Mem_Timeout=1 and Pipe_Freeze=1. Pulse rst -> Mem_Timeout=0, FSM in STARTUP.
- HAZARD_PERF_CNT_EN with CNT_W=4: 20 load-use events -> Load_Stall_Cnt saturates at 15.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard controller bundle: hazard sense inputs
// and the PC / pipeline-register control outputs.
interface hazard_control_unit_if;
    logic [4:0] IFID_rs1;
    logic [4:0] IFID_rs2;
    logic [4:0] IDEX_rd;
    logic       IDEX_MemRead;
    logic       Branch_Taken;
    logic       Dmem_Req;
    logic       Dmem_Ready;
    logic       PC_Write;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic       Pipe_Freeze;
    logic       Mem_Timeout;

    modport master (
        output IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead,
        output Branch_Taken, Dmem_Req, Dmem_Ready,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
        input  Pipe_Freeze, Mem_Timeout
    );

    modport slave (
        input  IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead,
        input  Branch_Taken, Dmem_Req, Dmem_Ready,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
        output Pipe_Freeze, Mem_Timeout
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard sequencing FSM: startup bubble, load-use stall, branch flush,
// memory wait freeze and timeout halt. HAZARD_PERF_CNT_EN adds counters.
module hazard_control_unit #(
    parameter int STARTUP_CYCLES = 2,
    parameter int TIMEOUT        = 15,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    hazard_control_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Load_Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Wait_Cnt
`endif
);

    typedef enum logic [1:0] {
        STARTUP,
        RUN,
        MEM_WAIT,
        HALT
    } state_t;

    localparam logic [3:0] SU_INIT = 4'(STARTUP_CYCLES);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [3:0] su_cnt, su_cnt_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       timeout_q, timeout_next;

    logic mem_busy;
    logic load_use;
    logic rule_busy, rule_branch, rule_lu;
    logic pc_write, ifid_write, ifid_flush, idex_flush, freeze;

    assign mem_busy = bus.Dmem_Req & ~bus.Dmem_Ready;
    assign load_use = bus.IDEX_MemRead & (bus.IDEX_rd != 5'd0) &
                      ((bus.IDEX_rd == bus.IFID_rs1) |
                       (bus.IDEX_rd == bus.IFID_rs2));

    // Next-state, counter updates and Mealy control outputs
    always_comb begin
        state_next    = state;
        su_cnt_next   = su_cnt;
        wait_cnt_next = wait_cnt;
        timeout_next  = timeout_q;
        rule_busy     = 1'b0;
        rule_branch   = 1'b0;
        rule_lu       = 1'b0;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        freeze        = 1'b0;

        if (state == RUN || state == MEM_WAIT) begin
            if (mem_busy) begin
                rule_busy = 1'b1;
                freeze    = 1'b1;
            end else if (bus.Branch_Taken) begin
                rule_branch = 1'b1;
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (load_use) begin
                rule_lu    = 1'b1;
                idex_flush = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end

        unique case (state)
            STARTUP: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (su_cnt <= 4'd1) begin
                    state_next = RUN;
                end else begin
                    su_cnt_next = su_cnt - 4'd1;
                end
            end
            RUN: begin
                if (mem_busy) begin
                    // The first busy cycle already counts toward the limit
                    if (TIMEOUT == 1) begin
                        state_next   = HALT;
                        timeout_next = 1'b1;
                    end else begin
                        state_next    = MEM_WAIT;
                        wait_cnt_next = 8'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_next = RUN;
                end else if (wait_cnt == TO_LAST) begin
                    state_next   = HALT;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_next = STARTUP;
            end
        endcase
    end

    // State, startup/wait counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STARTUP;
            su_cnt    <= SU_INIT;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            su_cnt    <= su_cnt_next;
            wait_cnt  <= wait_cnt_next;
            timeout_q <= timeout_next;
        end
    end

    assign bus.PC_Write    = pc_write;
    assign bus.IFID_Write  = ifid_write;
    assign bus.IFID_Flush  = ifid_flush;
    assign bus.IDEX_Flush  = idex_flush;
    assign bus.Pipe_Freeze = freeze;
    assign bus.Mem_Timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for stall, flush and wait cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Load_Stall_Cnt <= '0;
            Flush_Cnt      <= '0;
            Wait_Cnt       <= '0;
        end else begin
            if (rule_lu && !(&Load_Stall_Cnt))
                Load_Stall_Cnt <= Load_Stall_Cnt + 1'b1;
            if (rule_branch && !(&Flush_Cnt))
                Flush_Cnt <= Flush_Cnt + 1'b1;
            if ((rule_busy || state == HALT) && !(&Wait_Cnt))
                Wait_Cnt <= Wait_Cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table plus
// hand-written startup, wait, timeout and reset sequences.
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, Mem_Timeout}
    localparam logic [5:0] O_START = 6'b001100;
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_BR    = 6'b111100;
    localparam logic [5:0] O_LU    = 6'b000100;
    localparam logic [5:0] O_BUSY  = 6'b000010;
    localparam logic [5:0] O_HALT  = 6'b000011;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [5:0] exp_q[$];

    hazard_control_unit_if bus();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] ls_cnt, fl_cnt, wt_cnt;
`endif

    hazard_control_unit #(
        .STARTUP_CYCLES(2),
        .TIMEOUT(15),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Load_Stall_Cnt(ls_cnt),
        .Flush_Cnt(fl_cnt),
        .Wait_Cnt(wt_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input vec_t v);
        bus.IFID_rs1     = v.rs1;
        bus.IFID_rs2     = v.rs2;
        bus.IDEX_rd      = v.rd;
        bus.IDEX_MemRead = v.mr;
        bus.Branch_Taken = v.br;
        bus.Dmem_Req     = v.req;
        bus.Dmem_Ready   = v.rdy;
    endtask

    task automatic clr_in();
        vec_t v;
        v = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, "clr"};
        set_in(v);
    endtask

    // Push expectation, sample at negedge, pop and compare, then advance
    task automatic step(input string name, input logic [5:0] exp);
        logic [5:0] got;
        logic [5:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        got = {bus.PC_Write, bus.IFID_Write, bus.IFID_Flush,
               bus.IDEX_Flush, bus.Pipe_Freeze, bus.Mem_Timeout};
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, "idle"};
        vecs[1] = '{5'd4, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,  "lu_rs2"};
        vecs[2] = '{5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,  "lu_rs1"};
        vecs[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN, "lu_rd0"};
        vecs[4] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN, "no_load"};
        vecs[5] = '{5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN, "no_match"};
        vecs[6] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,  "branch"};
        vecs[7] = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,  "br_lu"};
        vecs[8] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN, "req_rdy"};
        vecs[9] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN, "rdy_only"};

        rst = 1'b1;
        clr_in();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step("reset_hold", O_START);
        rst = 1'b0;
        step("startup1", O_START);
        step("startup2", O_START);
        step("first_run", O_RUN);

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i]);
            step(vecs[i].name, vecs[i].exp);
        end

        set_in(vecs[7]);
        step("br_lu_seq", O_BR);
        clr_in();
        step("br_lu_no_stall", O_RUN);

        bus.Dmem_Req     = 1'b1;
        bus.Dmem_Ready   = 1'b0;
        bus.Branch_Taken = 1'b1;
        for (int i = 0; i < 4; i++) step("wait_freeze", O_BUSY);
        bus.Dmem_Ready = 1'b1;
        step("wait_ready_branch", O_BR);
        clr_in();
        step("wait_back_run", O_RUN);

        bus.Dmem_Req   = 1'b1;
        bus.Dmem_Ready = 1'b0;
        step("drop_busy1", O_BUSY);
        step("drop_busy2", O_BUSY);
        bus.Dmem_Req     = 1'b0;
        bus.IDEX_MemRead = 1'b1;
        bus.IDEX_rd      = 5'd7;
        bus.IFID_rs1     = 5'd7;
        step("drop_lu", O_LU);
        clr_in();
        step("drop_run", O_RUN);

        bus.Dmem_Req   = 1'b1;
        bus.Dmem_Ready = 1'b0;
        for (int i = 1; i <= 15; i++) step("timeout_wait", O_BUSY);
        step("halt", O_HALT);
        bus.Dmem_Req   = 1'b0;
        bus.Dmem_Ready = 1'b1;
        step("halt_sticky", O_HALT);
        clr_in();
        rst = 1'b1;
        step("halt_reset", O_START);
        rst = 1'b0;
        step("post_halt_su1", O_START);
        step("post_halt_su2", O_START);
        step("post_halt_run", O_RUN);

`ifdef HAZARD_PERF_CNT_EN
        chk_val("wait_cnt_reset", int'(wt_cnt), 0);
        bus.IDEX_MemRead = 1'b1;
        bus.IDEX_rd      = 5'd5;
        bus.IFID_rs2     = 5'd5;
        for (int i = 0; i < 20; i++) step("perf_lu", O_LU);
        clr_in();
        @(negedge clk);
        chk_val("load_stall_sat", int'(ls_cnt), 15);
        chk_val("flush_cnt", int'(fl_cnt), 0);
        @(posedge clk);
        #1;
        bus.Branch_Taken = 1'b1;
        for (int i = 0; i < 3; i++) step("perf_br", O_BR);
        clr_in();
        @(negedge clk);
        chk_val("flush_cnt3", int'(fl_cnt), 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
